// File: rtl/restoration_pipe.sv
// restoration_pipe: 3-stage dehaze restoration J = A + ((I-A)*t_inv >> FRAC), clamped.
// Ports: clk/rst_n, in_valid/in_ready/sof/mono/t_inv/pix_in/a_in -> out_valid/out_ready/pix_out/out_sof/sat_cnt.
module restoration_pipe #(
  parameter int PIX_W = 8,
  parameter int T_W   = 12,
  parameter int FRAC  = 3,
  parameter int NCH   = 3,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               sof,
  input  logic               mono,
  input  logic [T_W-1:0]     t_inv,
  input  logic [NCH*PIX_W-1:0] pix_in,
  input  logic [NCH*PIX_W-1:0] a_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NCH*PIX_W-1:0] pix_out,
  output logic               out_sof,
  output logic [CNT_W-1:0]   sat_cnt
);

  localparam int DW = PIX_W + 1;
  localparam int PW = PIX_W + T_W + 1;
  localparam int SW = PW + 1;
  localparam logic [PIX_W-1:0] PMAX = '1;
  localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

  // S1
  logic                    s1_v_q, s1_v_d;
  logic                    s1_sof_q, s1_sof_d;
  logic [T_W-1:0]          s1_t_q, s1_t_d;
  logic signed [DW-1:0]    s1_diff_q [NCH];
  logic signed [DW-1:0]    s1_diff_d [NCH];
  logic [PIX_W-1:0]        s1_a_q [NCH];
  logic [PIX_W-1:0]        s1_a_d [NCH];
  // S2
  logic                    s2_v_q, s2_v_d;
  logic                    s2_sof_q, s2_sof_d;
  logic signed [PW-1:0]    s2_prod_q [NCH];
  logic signed [PW-1:0]    s2_prod_d [NCH];
  logic [PIX_W-1:0]        s2_a_q [NCH];
  logic [PIX_W-1:0]        s2_a_d [NCH];
  // S3 / output register
  logic                    out_v_q, out_v_d;
  logic                    out_sof_q, out_sof_d;
  logic [NCH*PIX_W-1:0]    pix_q, pix_d;
  logic [CNT_W-1:0]        sat_q, sat_d;

  logic                    adv;
  logic [PIX_W-1:0]        a_sel [NCH];
  logic signed [PW-1:0]    prod_w [NCH];
  logic signed [SW-1:0]    sum_w [NCH];
  logic [NCH*PIX_W-1:0]    clamp_w;
  logic [CNT_W:0]          nsat;
  logic [CNT_W:0]          cnt_sum;

  // Global stall: everything freezes while the output is held.
  assign adv       = ~(out_v_q & ~out_ready);
  assign in_ready  = adv;
  assign out_valid = out_v_q;
  assign out_sof   = out_sof_q;
  assign pix_out   = pix_q;
  assign sat_cnt   = sat_q;

  always_comb begin
    nsat    = '0;
    clamp_w = '0;
    for (int c = 0; c < NCH; c++) begin
      a_sel[c]  = mono ? a_in[PIX_W-1:0] : a_in[c*PIX_W +: PIX_W];
      prod_w[c] = (PW'(s1_diff_q[c]) * $signed(PW'(s1_t_q))) >>> FRAC;
      sum_w[c]  = SW'(s2_prod_q[c]) + $signed(SW'(s2_a_q[c]));
      if (sum_w[c] < 0) begin
        clamp_w[c*PIX_W +: PIX_W] = '0;
        nsat = nsat + ONE;
      end else if (sum_w[c] > $signed(SW'(PMAX))) begin
        clamp_w[c*PIX_W +: PIX_W] = PMAX;
        nsat = nsat + ONE;
      end else begin
        clamp_w[c*PIX_W +: PIX_W] = sum_w[c][PIX_W-1:0];
      end
    end
    cnt_sum = {1'b0, sat_q} + nsat;
  end

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_sof_d  = s1_sof_q;
    s1_t_d    = s1_t_q;
    s1_diff_d = s1_diff_q;
    s1_a_d    = s1_a_q;
    s2_v_d    = s2_v_q;
    s2_sof_d  = s2_sof_q;
    s2_prod_d = s2_prod_q;
    s2_a_d    = s2_a_q;
    out_v_d   = out_v_q;
    out_sof_d = out_sof_q;
    pix_d     = pix_q;
    sat_d     = sat_q;
    if (adv) begin
      s1_v_d   = in_valid;
      s1_sof_d = in_valid & sof;
      s1_t_d   = t_inv;
      for (int c = 0; c < NCH; c++) begin
        s1_a_d[c]    = a_sel[c];
        s1_diff_d[c] = $signed({1'b0, pix_in[c*PIX_W +: PIX_W]})
                     - $signed({1'b0, a_sel[c]});
      end
      s2_v_d    = s1_v_q;
      s2_sof_d  = s1_sof_q;
      s2_prod_d = prod_w;
      s2_a_d    = s1_a_q;
      out_v_d   = s2_v_q;
      out_sof_d = s2_v_q & s2_sof_q;
      if (s2_v_q) begin
        pix_d = clamp_w;
        // sof restarts the count; otherwise accumulate and stick at max.
        if (s2_sof_q) sat_d = nsat[CNT_W-1:0];
        else if (cnt_sum[CNT_W]) sat_d = '1;
        else sat_d = cnt_sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_sof_q  <= 1'b0;
      s1_t_q    <= '0;
      s2_v_q    <= 1'b0;
      s2_sof_q  <= 1'b0;
      out_v_q   <= 1'b0;
      out_sof_q <= 1'b0;
      pix_q     <= '0;
      sat_q     <= '0;
      for (int c = 0; c < NCH; c++) begin
        s1_diff_q[c] <= '0;
        s1_a_q[c]    <= '0;
        s2_prod_q[c] <= '0;
        s2_a_q[c]    <= '0;
      end
    end else begin
      s1_v_q    <= s1_v_d;
      s1_sof_q  <= s1_sof_d;
      s1_t_q    <= s1_t_d;
      s1_diff_q <= s1_diff_d;
      s1_a_q    <= s1_a_d;
      s2_v_q    <= s2_v_d;
      s2_sof_q  <= s2_sof_d;
      s2_prod_q <= s2_prod_d;
      s2_a_q    <= s2_a_d;
      out_v_q   <= out_v_d;
      out_sof_q <= out_sof_d;
      pix_q     <= pix_d;
      sat_q     <= sat_d;
    end
  end

endmodule

// File: tb/tb_restoration_pipe.sv
// tb_restoration_pipe: vector table, hand sequences and a randomized scoreboard
// for restoration_pipe at default parameters.
module tb_restoration_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sof = 1'b0;
  logic        mono = 1'b0;
  logic [11:0] t_inv = '0;
  logic [23:0] pix_in = '0;
  logic [23:0] a_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] pix_out;
  logic        out_sof;
  logic [15:0] sat_cnt;

  always #5 clk = ~clk;

  restoration_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sof(sof), .mono(mono), .t_inv(t_inv),
    .pix_in(pix_in), .a_in(a_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pix_out(pix_out), .out_sof(out_sof), .sat_cnt(sat_cnt)
  );

  typedef struct {
    logic        sof;
    logic        mono;
    logic [11:0] t;
    logic [23:0] i;
    logic [23:0] a;
    logic [23:0] j;
    logic [15:0] sat;
  } vec_t;

  typedef struct {
    logic [23:0] pix;
    logic        sof;
    int          nsat;
  } exp_t;

  localparam int NV = 11;
  vec_t vt [NV];
  exp_t q [$];
  int checks = 0;
  int errors = 0;
  int m_sat = 0;
  bit prev_ov = 0;
  bit prev_ordy = 1;
  logic [23:0] prev_pix;
  logic prev_sof;
  logic [15:0] prev_sat;

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] rep(input logic [7:0] x);
    return {x, x, x};
  endfunction

  // Reference: per-channel floor division with plain integers.
  function automatic void model(input logic [23:0] i, input logic [23:0] a,
                                input logic [11:0] t, input logic mn,
                                output logic [23:0] j, output int ns);
    int av, p, d, s;
    ns = 0;
    j = '0;
    for (int c = 0; c < 3; c++) begin
      av = mn ? int'(a[7:0]) : int'(a[c*8 +: 8]);
      p = (int'(i[c*8 +: 8]) - av) * int'(t);
      d = p / 8;
      if (p < 0 && (p % 8) != 0) d = d - 1;
      s = av + d;
      if (s < 0) begin s = 0; ns++; end
      else if (s > 255) begin s = 255; ns++; end
      j[c*8 +: 8] = s[7:0];
    end
  endfunction

  task automatic apply_vec(input vec_t v, input int k);
    @(negedge clk);
    in_valid = 1'b1; sof = v.sof; mono = v.mono;
    t_inv = v.t; pix_in = v.i; a_in = v.a; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk(out_valid == 1'b0, $sformatf("vec%0d_early", k), out_valid, 0);
    @(negedge clk);
    chk(out_valid == 1'b1, $sformatf("vec%0d_valid", k), out_valid, 1);
    chk(pix_out == v.j, $sformatf("vec%0d_pix", k), pix_out, v.j);
    chk(out_sof == v.sof, $sformatf("vec%0d_sof", k), out_sof, v.sof);
    chk(sat_cnt == v.sat, $sformatf("vec%0d_sat", k), sat_cnt, v.sat);
  endtask

  task automatic step(input bit iv, input bit ordy, input bit sf,
                      input bit mn, input logic [11:0] t,
                      input logic [23:0] i, input logic [23:0] a,
                      output bit acc);
    exp_t e;
    logic [23:0] j;
    int ns;
    @(negedge clk);
    if (prev_ov && !prev_ordy) begin
      chk(out_valid == 1'b1, "hold_valid", out_valid, 1);
      chk(pix_out == prev_pix, "hold_pix", pix_out, prev_pix);
      chk(out_sof == prev_sof, "hold_sof", out_sof, prev_sof);
      chk(sat_cnt == prev_sat, "hold_sat", sat_cnt, prev_sat);
    end else if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out: got pix %0h expected no beat", pix_out);
      end else begin
        e = q.pop_front();
        if (e.sof) m_sat = e.nsat;
        else m_sat = (m_sat + e.nsat > 65535) ? 65535 : m_sat + e.nsat;
        chk(pix_out == e.pix, "sb_pix", pix_out, e.pix);
        chk(out_sof == e.sof, "sb_sof", out_sof, e.sof);
        chk(sat_cnt == 16'(m_sat), "sb_sat", sat_cnt, m_sat);
      end
    end
    in_valid = iv; sof = sf; mono = mn; t_inv = t;
    pix_in = i; a_in = a; out_ready = ordy;
    #1;
    chk(in_ready == !(out_valid && !ordy), "in_ready", in_ready,
        !(out_valid && !ordy));
    acc = iv && in_ready;
    if (acc) begin
      model(i, a, t, mn, j, ns);
      e.pix = j; e.sof = sf; e.nsat = ns;
      q.push_back(e);
    end
    prev_ov = out_valid; prev_ordy = ordy;
    prev_pix = pix_out; prev_sof = out_sof; prev_sat = sat_cnt;
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    while ((q.size() > 0 || out_valid) && n < 40) begin
      step(0, 1, 0, 0, '0, '0, '0, acc);
      n++;
    end
    chk(q.size() == 0, "drain", q.size(), 0);
  endtask

  initial begin
    bit acc;
    int got;
    int cyc;
    logic [23:0] j;
    int ns;
    exp_t e;

    vt[0]  = '{1'b1, 1'b0, 12'd16, rep(8'd150), rep(8'd200), rep(8'd100), 16'd0};
    vt[1]  = '{1'b1, 1'b0, 12'd32, rep(8'd250), rep(8'd200), rep(8'd255), 16'd3};
    vt[2]  = '{1'b0, 1'b0, 12'd16, rep(8'd150), rep(8'd200), rep(8'd100), 16'd3};
    vt[3]  = '{1'b0, 1'b0, 12'd24, rep(8'd10),  rep(8'd50),  rep(8'd0),   16'd6};
    vt[4]  = '{1'b0, 1'b0, 12'd12, rep(8'd49),  rep(8'd50),  rep(8'd48),  16'd6};
    vt[5]  = '{1'b0, 1'b1, 12'd8,  rep(8'd100), {8'd20, 8'd20, 8'd180},
               rep(8'd100), 16'd6};
    vt[6]  = '{1'b0, 1'b0, 12'd16, rep(8'd100), {8'd20, 8'd20, 8'd180},
               {8'd180, 8'd180, 8'd20}, 16'd6};
    vt[7]  = '{1'b1, 1'b0, 12'd0,  rep(8'd3),   rep(8'd77),  rep(8'd77),  16'd0};
    vt[8]  = '{1'b1, 1'b0, 12'd4095, rep(8'd255), rep(8'd0), rep(8'd255), 16'd3};
    vt[9]  = '{1'b0, 1'b0, 12'd4095, rep(8'd0), rep(8'd255), rep(8'd0),   16'd6};
    vt[10] = '{1'b1, 1'b0, 12'd32, {8'd250, 8'd150, 8'd150}, rep(8'd200),
               {8'd255, 8'd0, 8'd0}, 16'd1};

    // Reset state
    repeat (2) @(negedge clk);
    chk(out_valid == 1'b0, "rst_valid", out_valid, 0);
    chk(out_sof == 1'b0, "rst_sof", out_sof, 0);
    chk(pix_out == 24'd0, "rst_pix", pix_out, 0);
    chk(sat_cnt == 16'd0, "rst_sat", sat_cnt, 0);
    chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) apply_vec(vt[k], k);
    m_sat = int'(vt[NV-1].sat);
    prev_ov = 0;

    // Back-to-back beats with a 4-cycle output stall in the middle
    got = 0;
    cyc = 0;
    while (got < 10 && cyc < 40) begin
      step(1, !(cyc >= 4 && cyc < 8), 1'b0, 1'b0, 12'($urandom_range(0, 40)),
           24'($urandom), 24'($urandom), acc);
      if (acc) got++;
      cyc++;
    end
    chk(got == 10, "b2b_accepted", got, 10);
    drain();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
           ($urandom_range(0, 3) == 0) ? 12'($urandom)
                                       : 12'($urandom_range(0, 40)),
           24'($urandom), 24'($urandom), acc);
    end
    drain();

    // Saturation counter sticks at its maximum, sof restarts it
    step(1, 1, 1, 0, 12'd4095, 24'hFFFFFF, 24'h0, acc);
    for (int n = 0; n < 21850; n++)
      step(1, 1, 0, 0, 12'd4095, 24'hFFFFFF, 24'h0, acc);
    drain();
    chk(sat_cnt == 16'hFFFF, "sat_cap", sat_cnt, 16'hFFFF);
    step(1, 1, 0, 0, 12'd4095, 24'h0, 24'hFFFFFF, acc);
    drain();
    chk(sat_cnt == 16'hFFFF, "sat_cap_hold", sat_cnt, 16'hFFFF);
    step(1, 1, 1, 0, 12'd4095, 24'h0, 24'hFFFFFF, acc);
    drain();

    // Reset mid-stream with two beats in flight
    step(1, 1, 1, 0, 12'd16, rep(8'd150), rep(8'd200), acc);
    step(1, 1, 0, 0, 12'd16, rep(8'd150), rep(8'd200), acc);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk(in_ready == 1'b1, "midrst_in_ready", in_ready, 1);
    @(negedge clk);
    chk(out_valid == 1'b0, "midrst_valid", out_valid, 0);
    chk(sat_cnt == 16'd0, "midrst_sat", sat_cnt, 0);
    chk(pix_out == 24'd0, "midrst_pix", pix_out, 0);
    chk(in_ready == 1'b1, "midrst_in_ready2", in_ready, 1);
    q.delete();
    m_sat = 0;
    rst_n = 1'b1;
    in_valid = 1'b1; sof = 1'b1; mono = 1'b0; t_inv = 12'd32;
    pix_in = rep(8'd250); a_in = rep(8'd200); out_ready = 1'b1;
    #1;
    chk(in_ready == 1'b1, "post_rst_ready", in_ready, 1);
    model(pix_in, a_in, t_inv, 1'b0, j, ns);
    e.pix = j; e.sof = 1'b1; e.nsat = ns;
    q.push_back(e);
    prev_ov = 0; prev_ordy = 1;
    for (int n = 0; n < 8; n++) step(0, 1, 0, 0, '0, '0, '0, acc);
    chk(q.size() == 0, "post_rst_beat", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/restoration_pipe.md
RESTORATION_PIPE -- requirements
Module: restoration_pipe

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel and atmospheric-light width per channel.
REQ-002 SHALL have parameter T_W, default 12, unsigned inverse-transmission (t_inv) width.
REQ-003 SHALL have parameter FRAC, default 3, fractional bits of t_inv (t_inv = 2^FRAC means 1.0).
REQ-004 SHALL have parameter NCH, default 3, colour channel count, packed channel 0 in LSBs.
REQ-005 SHALL have parameter CNT_W, default 16, saturation-counter width.
REQ-006 SHALL use one clock; reset is synchronous and active-low.
REQ-007 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-008 SHALL have ports: in_valid  in  1  input beat valid; in_ready  out  1  block accepts beat.
REQ-009 SHALL have ports: sof  in  1  first pixel of frame, qualified by in_valid&in_ready.
REQ-010 SHALL have ports: mono  in  1  grey mode, all channels use channel-0 A; sampled per beat.
REQ-011 SHALL have ports: t_inv  in  T_W  unsigned fixed-point 1/t, shared by all channels.
REQ-012 SHALL have ports: pix_in  in  NCH*PIX_W  hazy pixel I; a_in  in  NCH*PIX_W  atmospheric light A.
REQ-013 SHALL have ports: out_valid  out  1; out_ready  in  1; pix_out  out  NCH*PIX_W  restored pixel J.
REQ-014 SHALL have ports: out_sof  out  1  sof delayed with its pixel; sat_cnt  out  CNT_W  saturated samples in current frame.

Function
REQ-015 SHALL compute per channel J = A + floor(((I - A) * t_inv) / 2^FRAC), clamped to [0, 2^PIX_W-1].
REQ-016 SHALL form I - A as signed PIX_W+1 bits, product as signed PIX_W+T_W+1 bits, no intermediate truncation.
REQ-017 SHALL divide by arithmetic right shift (round toward minus infinity).
REQ-018 SHALL, when mono=1, use channel-0 A for every channel of that beat.
REQ-019 SHALL be a 3-stage pipeline: S1 registers difference, A, t_inv; S2 registers shifted product and A; S3 registers clamped sum.
REQ-020 SHALL have latency 3 cycles from accepted beat to out_valid with no backpressure; throughput 1 beat/cycle.
REQ-021 SHALL carry a valid bit and sof per stage; bubbles propagate as invalid stages.
REQ-022 SHALL drive in_ready = ~(out_valid & ~out_ready); when low, all stages hold contents.
REQ-023 SHALL advance a stage holding a bubble even while downstream stalls is NOT required; global stall only.
REQ-024 SHALL hold pix_out, out_sof, out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL accept a beat only when in_valid & in_ready; beats with in_ready=0 are ignored, not queued.
REQ-026 SHALL flag a sample saturated when the unclamped sum is <0 or >2^PIX_W-1, evaluated in S3.
REQ-027 SHALL update sat_cnt when a beat leaves S3 into the output register: set to count of saturated channels of that beat if its sof=1, else add that count.
REQ-028 SHALL hold sat_cnt at 2^CNT_W-1 once reached (no wrap) until next sof beat.
REQ-029 SHALL give precedence to sof restart over saturation hold in the same cycle.
REQ-030 SHALL require t_inv=0 to produce J=A (no special casing, falls out of REQ-015).

Reset
REQ-031 SHALL, when rst_n=0 at a rising clk edge, clear all stage valid bits, out_valid=0, out_sof=0, pix_out=0, sat_cnt=0.
REQ-032 SHALL drive in_ready=1 during and after reset (out_valid=0).
REQ-033 SHALL discard beats in flight when reset asserts mid-stream; no output for them after release.
REQ-034 SHALL accept a new beat on the first edge with rst_n=1.

Verification
REQ-035 SHALL pass: PIX_W=8,FRAC=3, A=200,I=150,t_inv=16 -> J=100 after 3 cycles, sat_cnt unchanged.
REQ-036 SHALL pass: A=200,I=250,t_inv=32 (sof=1) -> J=255, sat_cnt=1 per channel saturated (3 if all channels alike).
REQ-037 SHALL pass: A=50,I=10,t_inv=24 -> J=0 (unclamped -70); A=50,I=49,t_inv=12 -> J=48 (floor of -1.5 is -2).
REQ-038 SHALL pass: mono=1, a_in channels {R=180,G=20,B=20}, I all 100, t_inv=8 -> J all 100, A=180 used for G and B.
REQ-039 SHALL pass: 10 back-to-back beats, out_ready low 4 cycles mid-stream -> in_ready low those cycles, no beat lost/duplicated, order preserved, outputs stable.
REQ-040 SHALL pass: rst_n low 1 cycle with 2 beats in flight -> out_valid=0, sat_cnt=0 next cycle, no stale outputs afterwards.
